ika2151_dac_tx: RTL and testbench
=================================

// Module: ika2151_dac_tx
// PURPOSE
// Serial DAC transmitter at the chip's analogue-output edge. Once per 32-slot frame it latches two signed 16-bit accumulator sums (left, right).
// It encodes each sum into the 13-bit floating-point DAC word: 10-bit two's-complement mantissa plus 3-bit exponent.
// It shifts both words out on o_SO, with o_SH1/o_SH2 frame strobes, for an external YM3012-style DAC receiver.
// PARAMETERS
// SH_LEN    8   slots per word during which the channel strobe is high (1..16); high over the last SH_LEN slots of the word
// PAD_BITS  3   zero bits sent before the mantissa; fixed so that PAD_BITS+10+3 = 16
// PORTS
// i_EMUCLK        in   1   emulator master clock
// i_MRST          in   1   synchronous reset, active high
// i_phi1_NCEN_n   in   1   phi1 negative-edge clock enable; one "slot" per asserted (low) enable
// i_CYCLE_SYNC    in   1   frame-start timing pulse, sampled on the NCEN slot
// i_ACC_L         in   16  signed left accumulator sum
// i_ACC_R         in   16  signed right accumulator sum
// o_SO            out  1   serial DAC data
// o_SH1           out  1   left-channel strobe
// o_SH2           out  1   right-channel strobe
// o_DBG_L         out  13  last encoded left word {exp[2:0], mant[9:0]}
// o_DBG_R         out  13  last encoded right word {exp[2:0], mant[9:0]}
// BEHAVIOUR
// - Reset: one clock synchronous, and it overrides the enable. Afterwards: state=IDLE, slot counter=0, o_SO=0, o_SH1=0, o_SH2=0, o_DBG_L=0, o_DBG_R=0.
// - Reset during a frame aborts that frame immediately, and the next clock edge shows all outputs at their reset values.
// - All state updates only on i_EMUCLK edges with i_phi1_NCEN_n=0. Outputs are registered.
// - Encode x[15:0]: n = smallest value in 0..6 with x[15:9+n] all equal (n=6 always qualifies).
//   Then mant = x[9+n:n], exp = n+1 (range 1..7). exp=0 is never emitted. The n LSBs of x are truncated, with no rounding.
// - FSM IDLE: outputs held at 0. A slot with i_CYCLE_SYNC=1 latches and encodes both inputs, sets cnt=0, and goes to RUN.
// - FSM RUN: each slot, cnt <= cnt+1 (5-bit, wrapping 31->0).
//   - Wrap 31->0: re-latches and re-encodes the inputs, so the block free-runs without SYNC.
//   - SYNC in RUN at any cnt: re-latches, forces cnt=0 and abandons the current frame (resync). SYNC at cnt=31 is identical to a wrap.
// - Latch is the same slot as the load. o_DBG_L/R update on that slot.
// - Frame bit b (0..15) of a word = {exp[2:0], mant[9:0], 3'b000}[b]: pad first, then mantissa LSB-first, then exponent LSB-first.
// - o_SO in slot cnt: cnt 0..15 -> left bit cnt; cnt 16..31 -> right bit cnt-16. The slot-0 value is driven by the same slot that loads.
// - o_SH1 = RUN && cnt in [16-SH_LEN, 15]. o_SH2 = RUN && cnt in [32-SH_LEN, 31].
//   The receiver latches the word on the strobe's falling edge. Both strobes are never high together.
// - Inputs may change at any time. Only values present at the load slot are transmitted.
// TESTING
// - Reset, then 40 slots with no SYNC -> o_SO=o_SH1=o_SH2=0 and o_DBG_L=o_DBG_R=0 throughout.
// - L=16'h0000, R=16'h7FFF, one SYNC -> o_DBG_L=13'h0400 (exp1, mant 0); o_DBG_R={3'd7,10'h1FF}.
//   Serial output: slots 0..15 = 0000000000000100, slots 16..31 = 000 1111111110 111.
// - Encoding table: 16'h0100->e1 m0x100; 16'hFE00->e1 m0x200; 16'h0400->e3 m0x100; 16'h8000->e7 m0x200; 16'hFFFF->e1 m0x3FF.
// - Strobes with SH_LEN=8 -> o_SH1 high in slots 8..15 only, o_SH2 high in slots 24..31 only. A second frame after the wrap repeats this without SYNC.
// - SYNC at cnt=10 with new inputs -> next slot shows cnt=0 pattern of the new left word; o_SH1 drops and rises again at cnt 8.
// - Assert i_MRST at cnt=20 -> next edge all outputs 0 and state IDLE. Release, then SYNC -> normal frame from slot 0.

Source files
------------

// File: rtl/ika2151_dac_tx.sv
// Serial DAC transmitter: once per 32-slot frame it latches the left/right sums, converts each to a
// 13-bit float word (10-bit mantissa, 3-bit exponent) and shifts both out with SH1/SH2 word strobes.
module ika2151_dac_tx #(
    parameter int SH_LEN   = 8,
    parameter int PAD_BITS = 3
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_SYNC,
    input  logic [15:0] i_ACC_L,
    input  logic [15:0] i_ACC_R,
    output logic        o_SO,
    output logic        o_SH1,
    output logic        o_SH2,
    output logic [12:0] o_DBG_L,
    output logic [12:0] o_DBG_R
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [12:0] word_l_reg, word_l_next;
    logic [12:0] word_r_reg, word_r_next;
    logic        so_reg, so_next;
    logic        sh1_reg, sh1_next;
    logic        sh2_reg, sh2_next;
    logic        load;

    logic [31:0] acc_cat;
    logic [25:0] enc_cat;

    assign acc_cat = {i_ACC_R, i_ACC_L};

    // One encoder per channel: shift right by the fewest bits that leave a 10-bit signed value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_enc
            logic [15:0] x;
            logic [2:0]  n;
            logic        ok;
            assign x = acc_cat[gi*16 +: 16];
            always_comb begin
                n  = 3'd6;
                ok = 1'b1;
                for (int k = 5; k >= 0; k--) begin
                    ok = ok & (x[9+k] == x[15]);
                    if (ok) n = 3'(k);
                end
            end
            assign enc_cat[gi*13 +: 13] = {n + 3'd1, 10'(x >> n)};
        end
    endgenerate

    logic [12+PAD_BITS:0] frame_l, frame_r;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        word_l_next = word_l_reg;
        word_r_next = word_r_reg;
        load        = 1'b0;
        if (!i_phi1_NCEN_n) begin
            case (state_reg)
                IDLE: begin
                    if (i_CYCLE_SYNC) begin
                        load       = 1'b1;
                        state_next = RUN;
                        cnt_next   = 5'd0;
                    end
                end
                RUN: begin
                    // A wrap and a resync are the same event: reload and restart at slot 0.
                    if (i_CYCLE_SYNC || cnt_reg == 5'd31) begin
                        load     = 1'b1;
                        cnt_next = 5'd0;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        if (load) begin
            word_l_next = enc_cat[12:0];
            word_r_next = enc_cat[25:13];
        end
        // Outputs are registered from next-state so slot 0 is driven by the loading slot.
        frame_l  = {word_l_next, {PAD_BITS{1'b0}}};
        frame_r  = {word_r_next, {PAD_BITS{1'b0}}};
        so_next  = (state_next == RUN) &&
                   (cnt_next[4] ? frame_r[cnt_next[3:0]] : frame_l[cnt_next[3:0]]);
        sh1_next = (state_next == RUN) && !cnt_next[4] && (cnt_next[3:0] >= 4'(16 - SH_LEN));
        sh2_next = (state_next == RUN) &&  cnt_next[4] && (cnt_next[3:0] >= 4'(16 - SH_LEN));
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            state_reg  <= IDLE;
            cnt_reg    <= 5'd0;
            word_l_reg <= 13'd0;
            word_r_reg <= 13'd0;
            so_reg     <= 1'b0;
            sh1_reg    <= 1'b0;
            sh2_reg    <= 1'b0;
        end else if (!i_phi1_NCEN_n) begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            word_l_reg <= word_l_next;
            word_r_reg <= word_r_next;
            so_reg     <= so_next;
            sh1_reg    <= sh1_next;
            sh2_reg    <= sh2_next;
        end
    end

    assign o_SO    = so_reg;
    assign o_SH1   = sh1_reg;
    assign o_SH2   = sh2_reg;
    assign o_DBG_L = word_l_reg;
    assign o_DBG_R = word_r_reg;

endmodule

// File: tb/tb_ika2151_dac_tx.sv
// Scoreboard bench for ika2151_dac_tx: a slot-level reference model queues the expected outputs of
// every clock, and a monitor pops and compares them just after each rising edge.
module tb_ika2151_dac_tx;

    localparam int SH = 8;

    logic        clk = 1'b0;
    logic        mrst = 1'b1;
    logic        ncen = 1'b1;
    logic        sync_i = 1'b0;
    logic [15:0] acc_l = 16'd0;
    logic [15:0] acc_r = 16'd0;
    logic        so, sh1, sh2;
    logic [12:0] dbg_l, dbg_r;

    ika2151_dac_tx #(.SH_LEN(SH), .PAD_BITS(3)) dut (
        .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen), .i_CYCLE_SYNC(sync_i),
        .i_ACC_L(acc_l), .i_ACC_R(acc_r),
        .o_SO(so), .o_SH1(sh1), .o_SH2(sh2), .o_DBG_L(dbg_l), .o_DBG_R(dbg_r)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;
    logic [28:0] exp_q[$];

    // Reference model state: running flag, slot number, latched words, current expected outputs.
    bit          m_run = 0;
    int          m_cnt = 0;
    logic [12:0] m_wl = 0, m_wr = 0;
    logic [28:0] m_out = 0;

    // Float encode from the value range: pick the smallest shift n for which x fits in 10+n signed bits.
    function automatic logic [12:0] m_enc(input logic [15:0] x);
        int v, n;
        v = int'($signed(x));
        n = 0;
        while (n < 6 && !(v >= -(512 << n) && v < (512 << n))) n++;
        return {3'(n + 1), 10'((v >>> n) & 1023)};
    endfunction

    function automatic logic m_bit(input logic [12:0] w, input int b);
        int frame;
        frame = (int'(w[12:10]) << 13) | (int'(w[9:0]) << 3);
        return logic'((frame >> b) & 1);
    endfunction

    task automatic cyc(input bit rst, input bit en, input bit sy, input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        mrst = rst; ncen = !en; sync_i = sy; acc_l = l; acc_r = r;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_wl = 0; m_wr = 0; m_out = 0;
        end else if (en) begin
            if ((!m_run && sy) || (m_run && (sy || m_cnt == 31))) begin
                m_run = 1; m_cnt = 0; m_wl = m_enc(l); m_wr = m_enc(r);
            end else if (m_run) begin
                m_cnt = m_cnt + 1;
            end
            m_out = {m_run && m_bit(m_cnt < 16 ? m_wl : m_wr, m_cnt % 16),
                     m_run && m_cnt >= 16 - SH && m_cnt <= 15,
                     m_run && m_cnt >= 32 - SH,
                     m_wl, m_wr};
        end
        exp_q.push_back(m_out);
        started = 1;
    endtask

    // One enabled slot, preceded by 0..2 disabled clocks during which nothing may change.
    task automatic slot(input bit sy, input logic [15:0] l, input logic [15:0] r);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) cyc(0, 0, $urandom_range(0, 1), 16'($urandom), 16'($urandom));
        cyc(0, 1, sy, l, r);
    endtask

    initial begin : monitor
        logic [28:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {so, sh1, sh2, dbg_l, dbg_r};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL slot_out t=%0t got so=%b sh1=%b sh2=%b l=%h r=%h want so=%b sh1=%b sh2=%b l=%h r=%h",
                             $time, a[28], a[27], a[26], a[25:13], a[12:0],
                             e[28], e[27], e[26], e[25:13], e[12:0]);
                end
            end else if (started) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty t=%0t got no expectation want one per clock", $time);
            end
        end
    end

    logic [15:0] tv[5];
    logic [12:0] te[5];

    initial begin
        int guard;
        tv[0] = 16'h0100; te[0] = {3'd1, 10'h100};
        tv[1] = 16'hFE00; te[1] = {3'd1, 10'h200};
        tv[2] = 16'h0400; te[2] = {3'd3, 10'h100};
        tv[3] = 16'h8000; te[3] = {3'd7, 10'h200};
        tv[4] = 16'hFFFF; te[4] = {3'd1, 10'h3FF};

        // Reset, then idle with no SYNC.
        cyc(1, 1, 0, 16'h1234, 16'h5678);
        cyc(1, 0, 1, 16'h1234, 16'h5678);
        for (int i = 0; i < 40; i++) slot(0, 16'($urandom), 16'($urandom));

        // Known frame (0 / 7FFF), then a second frame from the wrap with no SYNC.
        slot(1, 16'h0000, 16'h7FFF);
        @(posedge clk); #2;
        n_cmp++;
        if (dbg_l !== 13'h0400 || dbg_r !== {3'd7, 10'h1FF}) begin
            n_bad++;
            $display("FAIL dbg_known got l=%h r=%h want l=0400 r=%h", dbg_l, dbg_r, {3'd7, 10'h1FF});
        end
        for (int i = 0; i < 31; i++) slot(0, 16'h0000, 16'h7FFF);
        for (int i = 0; i < 40; i++) slot(0, 16'($urandom), 16'($urandom));

        // Encoding table through the load path.
        for (int t = 0; t < 5; t++) begin
            slot(1, tv[t], ~tv[t]);
            @(posedge clk); #2;
            n_cmp++;
            if (dbg_l !== te[t]) begin
                n_bad++;
                $display("FAIL enc_table x=%h got %h want %h", tv[t], dbg_l, te[t]);
            end
            for (int i = 0; i < 4; i++) slot(0, 16'($urandom), 16'($urandom));
        end

        // Resync at slot 10 with new inputs.
        guard = 0;
        while (m_cnt != 10 && guard < 64) begin slot(0, 16'($urandom), 16'($urandom)); guard++; end
        slot(1, 16'hC3A5, 16'h0042);
        for (int i = 0; i < 20; i++) slot(0, 16'($urandom), 16'($urandom));

        // Reset at slot 20, release, then a fresh frame.
        guard = 0;
        while (m_cnt != 20 && guard < 64) begin slot(0, 16'($urandom), 16'($urandom)); guard++; end
        cyc(1, 0, 0, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 5; i++) slot(0, 16'($urandom), 16'($urandom));
        slot(1, 16'h2001, 16'hDFFF);
        for (int i = 0; i < 40; i++) slot(0, 16'($urandom), 16'($urandom));

        // Random soak: irregular enables, occasional SYNC and reset.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 39) == 0, 16'($urandom), 16'($urandom));
        end

        @(posedge clk); #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
